// File: rtl/intt_butterfly_unit.sv
// Two-stage Gentleman-Sande inverse-NTT butterfly: s = (a +/- b) * c mod q,
// q = 2^(N-1)+1. Stage 1 does the modular add/sub, stage 2 the modular multiply.

module intt_modmul #(
   parameter int LOGQ = 9
) (
   input  logic [LOGQ-1:0] a,
   input  logic [LOGQ-1:0] b,
   output logic [LOGQ-1:0] p
);
   localparam int unsigned Q = (1 << (LOGQ-1)) + 1;
   localparam logic [LOGQ+1:0] QW = (LOGQ+2)'(Q);

   logic [2*LOGQ-1:0] x;
   logic [LOGQ-2:0] lo;
   logic [LOGQ-2:0] mid;
   logic [1:0] hi;
   logic [LOGQ+1:0] r0;
   logic [LOGQ+1:0] r1;
   logic [LOGQ+1:0] r2;

   // 2^(LOGQ-1) == -1 mod q, so x == lo - mid + hi; the +q keeps r0 non-negative
   always_comb begin
      x = {{LOGQ{1'b0}}, a} * {{LOGQ{1'b0}}, b};
      lo = x[LOGQ-2:0];
      mid = x[2*LOGQ-3:LOGQ-1];
      hi = x[2*LOGQ-1:2*LOGQ-2];
      r0 = {3'b000, lo} + QW + {{LOGQ{1'b0}}, hi} - {3'b000, mid};
      r1 = (r0 >= QW) ? r0 - QW : r0;
      r2 = (r1 >= QW) ? r1 - QW : r1;
      p = r2[LOGQ-1:0];
   end
endmodule

module intt_butterfly_unit #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic         sub,
   output logic         out_valid,
   output logic [N-1:0] s
);
   localparam int unsigned Q = (1 << (N-1)) + 1;
   localparam logic [N+1:0] QW = (N+2)'(Q);

   logic         s1_valid_q, s1_valid_d;
   logic [N-1:0] t_q, t_d;
   logic [N-1:0] c_q, c_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] s_q, s_d;
   logic [N-1:0] p;

   logic [N+1:0] sum;
   logic [N+1:0] dif;
   logic [N+1:0] t_full;

   always_comb begin
      sum = {2'b00, a} + {2'b00, b};
      dif = {2'b00, a} + QW - {2'b00, b};
      t_full = sub ? dif : sum;
      if (t_full >= QW) t_full = t_full - QW;
      s1_valid_d = in_valid;
      t_d = in_valid ? t_full[N-1:0] : t_q;
      c_d = in_valid ? c : c_q;
   end

   intt_modmul #(.LOGQ(N)) u_mul (
      .a (t_q),
      .b (c_q),
      .p (p)
   );

   // s keeps the last valid result through bubbles
   always_comb begin
      out_valid_d = s1_valid_q;
      s_d = s1_valid_q ? p : s_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         t_q <= '0;
         c_q <= '0;
         out_valid_q <= 1'b0;
         s_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         t_q <= t_d;
         c_q <= c_d;
         out_valid_q <= out_valid_d;
         s_q <= s_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s = s_q;
endmodule

// File: tb/tb_intt_butterfly_unit.sv
// Bench for intt_butterfly_unit: directed vectors at N=9, random stream at N=9,
// exhaustive stream at N=5, both checked against an arithmetic reference.

module tb_intt_butterfly_unit;
   logic clk = 1'b0;
   logic rst;

   logic       iv9, sub9, ov9;
   logic [8:0] a9, b9, c9, s9;
   logic       iv5, sub5, ov5;
   logic [4:0] a5, b5, c5, s5;

   int n_checks = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;
   int q9[$];
   int q5[$];

   typedef struct {
      int a;
      int b;
      int c;
      int sub;
      int exp;
   } vec_t;
   vec_t vecs[11];

   always #5 clk = ~clk;

   intt_butterfly_unit #(.N(9)) dut9 (
      .clk(clk), .rst(rst), .in_valid(iv9),
      .a(a9), .b(b9), .c(c9), .sub(sub9),
      .out_valid(ov9), .s(s9)
   );

   intt_butterfly_unit #(.N(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(iv5),
      .a(a5), .b(b5), .c(c5), .sub(sub5),
      .out_valid(ov5), .s(s5)
   );

   function automatic int ref_bf(int a, int b, int c, int sub, int q);
      int t;
      t = sub ? (a - b + q) % q : (a + b) % q;
      return (t * c) % q;
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (ov9) begin
            if (q9.size() == 0) check("n9 unexpected out_valid", 1, 0);
            else check("n9 stream s", int'(s9), q9.pop_front());
         end
         if (ov5) begin
            if (q5.size() == 0) check("n5 unexpected out_valid", 1, 0);
            else check("n5 stream s", int'(s5), q5.pop_front());
         end
      end
   end

   task automatic run_vec(vec_t v);
      @(negedge clk);
      a9 = 9'(v.a); b9 = 9'(v.b); c9 = 9'(v.c); sub9 = v.sub[0];
      iv9 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      iv9 = 1'b0;
      @(posedge clk); #1;
      check("vec out_valid", int'(ov9), 1);
      check("vec s", int'(s9), v.exp);
      @(posedge clk); #1;
      check("vec bubble out_valid", int'(ov9), 0);
      check("vec s hold", int'(s9), v.exp);
   endtask

   initial begin
      vecs[0]  = '{a: 5,   b: 3,   c: 1,   sub: 0, exp: 8};
      vecs[1]  = '{a: 3,   b: 5,   c: 1,   sub: 1, exp: 255};
      vecs[2]  = '{a: 7,   b: 7,   c: 1,   sub: 1, exp: 0};
      vecs[3]  = '{a: 200, b: 100, c: 1,   sub: 0, exp: 43};
      vecs[4]  = '{a: 128, b: 129, c: 1,   sub: 0, exp: 0};
      vecs[5]  = '{a: 10,  b: 4,   c: 241, sub: 1, exp: 161};
      vecs[6]  = '{a: 256, b: 0,   c: 256, sub: 0, exp: 1};
      vecs[7]  = '{a: 1,   b: 0,   c: 225, sub: 0, exp: 225};
      vecs[8]  = '{a: 8,   b: 0,   c: 225, sub: 0, exp: 1};
      vecs[9]  = '{a: 100, b: 50,  c: 0,   sub: 0, exp: 0};
      vecs[10] = '{a: 0,   b: 256, c: 256, sub: 1, exp: 256};

      rst = 1'b1;
      iv9 = 1'b0; a9 = '0; b9 = '0; c9 = '0; sub9 = 1'b0;
      iv5 = 1'b0; a5 = '0; b5 = '0; c5 = '0; sub5 = 1'b0;
      #1;
      check("reset out_valid", int'(ov9), 0);
      check("reset s", int'(s9), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // reset mid-stream: in-flight ops must vanish
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a9 = 9'(10 + i); b9 = 9'(20); c9 = 9'(3); sub9 = 1'b0;
         iv9 = 1'b1;
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async rst out_valid", int'(ov9), 0);
      check("async rst s", int'(s9), 0);
      @(posedge clk); #1;
      check("held rst out_valid", int'(ov9), 0);
      @(negedge clk);
      rst = 1'b0;
      a9 = 9'd5; b9 = 9'd3; c9 = 9'd1; sub9 = 1'b0;
      iv9 = 1'b1;
      @(posedge clk); #1;
      check("post rst edge1 out_valid", int'(ov9), 0);
      @(negedge clk);
      iv9 = 1'b0;
      @(posedge clk); #1;
      check("post rst edge2 out_valid", int'(ov9), 1);
      check("post rst s", int'(s9), 8);
      @(posedge clk); #1;
      check("post rst bubble", int'(ov9), 0);

      // random stream at N=9 with random bubbles
      mon_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         int ra, rb, rc, rs;
         @(negedge clk);
         ra = int'($urandom_range(256, 0));
         rb = int'($urandom_range(256, 0));
         rc = int'($urandom_range(256, 0));
         rs = int'($urandom_range(1, 0));
         a9 = 9'(ra); b9 = 9'(rb); c9 = 9'(rc); sub9 = rs[0];
         iv9 = 1'($urandom_range(1, 0));
         if (iv9) q9.push_back(ref_bf(ra, rb, rc, rs, 257));
      end
      @(negedge clk);
      iv9 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("n9 stream drained", q9.size(), 0);

      // exhaustive back-to-back stream at N=5
      for (int ea = 0; ea < 17; ea++)
         for (int eb = 0; eb < 17; eb++)
            for (int ec = 0; ec < 17; ec++)
               for (int es = 0; es < 2; es++) begin
                  @(negedge clk);
                  a5 = 5'(ea); b5 = 5'(eb); c5 = 5'(ec); sub5 = es[0];
                  iv5 = 1'b1;
                  q5.push_back(ref_bf(ea, eb, ec, es, 17));
               end
      @(negedge clk);
      iv5 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("n5 stream drained", q5.size(), 0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
